divn_tick_sched: RTL and testbench



---
 rtl/divn_pkg.sv | 15 +
 rtl/divn_counter.sv | 27 ++
 rtl/divn_tick_sched.sv | 101 ++++++++++
 tb/tb_divn_tick_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/divn_pkg.sv
// Shared types and constants for the divide-by-N tick scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package divn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } divn_state_t;

    // Smallest divisor that still yields a distinct tick and last cycle.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/divn_counter.sv
// Phase counter: counts 0..max and wraps to 0, with a synchronous clear.
// Latency: phase updates one clock after clr/inc; at_max is combinational on phase/max.
// Backpressure: none; inc is honoured on every cycle it is asserted.
module divn_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] phase,
    output logic             at_max
);

    assign at_max = (phase == max);

    // Clear has priority over counting; counting wraps from max back to zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase <= '0;
        end else if (inc) begin
            phase <= at_max ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/divn_tick_sched.sv
// Programmable divide-by-N tick scheduler with boundary-aligned start/stop and divisor changes.
// Latency: first tick one cycle after en is sampled high; divisor changes in RUN land on the next period boundary.
// Backpressure: cfg_ready drops while a deferred divisor is pending or while stopping.
module divn_tick_sched
    import divn_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             tick,
    output logic             last,
    output logic [WIDTH-1:0] phase,
    output logic             busy,
    output logic [WIDTH-1:0] div_cur
);

    divn_state_t      state;
    divn_state_t      state_nxt;
    logic             pend_v;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] div_max;
    logic             at_max;
    logic             accept;
    logic             cfg_bad;

    // All outputs below decode registered state only, so no input reaches an output combinationally.
    assign busy      = (state != IDLE);
    assign div_max   = div_cur - 1'b1;
    assign tick      = busy && (phase == '0);
    assign last      = busy && at_max;
    assign cfg_ready = (state == IDLE) || ((state == RUN) && !pend_v);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_bad   = (cfg_div < WIDTH'(DIV_MIN));

    // Phase only advances while running or draining; IDLE holds it at zero.
    divn_counter #(.WIDTH(WIDTH)) u_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == IDLE),
        .inc    (busy),
        .max    (div_max),
        .phase  (phase),
        .at_max (at_max)
    );

    // Next-state: STOP drains to the period boundary unless en comes back first.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (en)          state_nxt = RUN;
                else if (at_max) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Divisor handling: immediate in IDLE, deferred to the next boundary otherwise; bad values only flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cur  <= WIDTH'(DEFAULT_DIV);
            pend_v   <= 1'b0;
            pend_div <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= accept && cfg_bad;
            // Uses the registered pend_v, so a divisor accepted on a last cycle waits a full period.
            if (last && pend_v) begin
                div_cur <= pend_div;
                pend_v  <= 1'b0;
            end
            if (accept && !cfg_bad) begin
                if (state == IDLE) begin
                    div_cur <= cfg_div;
                end else begin
                    pend_div <= cfg_div;
                    pend_v   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_divn_tick_sched.sv
module tb_divn_tick_sched;

    typedef struct packed {
        logic       tick;
        logic       last;
        logic       busy;
        logic       rdy;
        logic       err;
        logic [7:0] phase;
        logic [7:0] div;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       vld;
        logic [7:0] d;
        out_t       exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick;
    logic       last;
    logic [7:0] phase;
    logic       busy;
    logic [7:0] div_cur;

    int n_checks;
    int n_fail;

    vec_t tbl[$];

    divn_tick_sched #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .last      (last),
        .phase     (phase),
        .busy      (busy),
        .div_cur   (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic v, input int d,
                                input logic t, input logic l, input logic b, input logic rd,
                                input logic er, input int ph, input int dv);
        vec_t x;
        x.rst       = r;
        x.en        = e;
        x.vld       = v;
        x.d         = 8'(d);
        x.exp.tick  = t;
        x.exp.last  = l;
        x.exp.busy  = b;
        x.exp.rdy   = rd;
        x.exp.err   = er;
        x.exp.phase = 8'(ph);
        x.exp.div   = 8'(dv);
        return x;
    endfunction

    // One clock: drive inputs, take the edge, sample 1ns later and compare every output.
    task automatic cyc(input string name, input logic r, input logic e, input logic v, input int d,
                       input logic t, input logic l, input logic b, input logic rd,
                       input logic er, input int ph, input int dv);
        vec_t x;
        out_t act;
        x = mk(r, e, v, d, t, l, b, rd, er, ph, dv);
        reset     = x.rst;
        en        = x.en;
        cfg_valid = x.vld;
        cfg_div   = x.d;
        @(posedge clk);
        #1;
        act.tick  = tick;
        act.last  = last;
        act.busy  = busy;
        act.rdy   = cfg_ready;
        act.err   = cfg_err;
        act.phase = phase;
        act.div   = div_cur;
        n_checks++;
        if (act !== x.exp) begin
            n_fail++;
            $display("FAIL %s: got tick=%b last=%b busy=%b rdy=%b err=%b phase=%0d div=%0d, want tick=%b last=%b busy=%b rdy=%b err=%b phase=%0d div=%0d",
                     name, act.tick, act.last, act.busy, act.rdy, act.err, act.phase, act.div,
                     x.exp.tick, x.exp.last, x.exp.busy, x.exp.rdy, x.exp.err, x.exp.phase, x.exp.div);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;

        // Reset, then free-run at the default divisor of 3.
        tbl.push_back(mk(1,0,0,0, 0,0,0,1,0,0,3));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0,1,0,0, (i%3)==0, (i%3)==2, 1,1,0, i%3, 3));
        // Invalid divisors 1 and 0 while running: err pulse only.
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,3));
        tbl.push_back(mk(0,1,1,1, 0,0,1,1,1,1,3));
        tbl.push_back(mk(0,1,0,0, 0,1,1,1,0,2,3));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,3));
        tbl.push_back(mk(0,1,1,0, 0,0,1,1,1,1,3));
        tbl.push_back(mk(0,1,0,0, 0,1,1,1,0,2,3));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,3));
        // Divisor 7 accepted at phase 1, applied at the next boundary.
        tbl.push_back(mk(0,1,0,0, 0,0,1,1,0,1,3));
        tbl.push_back(mk(0,1,1,7, 0,1,1,0,0,2,3));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,7));
        for (int p = 1; p <= 6; p++)
            tbl.push_back(mk(0,1,0,0, 0,p==6,1,1,0,p,7));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,7));
        // Divisor 5 loaded in IDLE, then run one period.
        tbl.push_back(mk(1,0,0,0, 0,0,0,1,0,0,3));
        tbl.push_back(mk(0,0,1,5, 0,0,0,1,0,0,5));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,5));
        for (int p = 1; p <= 4; p++)
            tbl.push_back(mk(0,1,0,0, 0,p==4,1,1,0,p,5));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,5));
        // Divisor 4: stop at phase 1, drain to IDLE; then resume from STOP at phase 2.
        tbl.push_back(mk(1,0,0,0, 0,0,0,1,0,0,3));
        tbl.push_back(mk(0,0,1,4, 0,0,0,1,0,0,4));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,4));
        tbl.push_back(mk(0,1,0,0, 0,0,1,1,0,1,4));
        tbl.push_back(mk(0,0,0,0, 0,0,1,0,0,2,4));
        tbl.push_back(mk(0,0,0,0, 0,1,1,0,0,3,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,0,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1,0,0,4));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,4));
        tbl.push_back(mk(0,1,0,0, 0,0,1,1,0,1,4));
        tbl.push_back(mk(0,0,0,0, 0,0,1,0,0,2,4));
        tbl.push_back(mk(0,1,0,0, 0,1,1,1,0,3,4));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,4));
        // Divisor 6 with 9 pending, reset at phase 3 discards everything.
        tbl.push_back(mk(1,0,0,0, 0,0,0,1,0,0,3));
        tbl.push_back(mk(0,0,1,6, 0,0,0,1,0,0,6));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,6));
        tbl.push_back(mk(0,1,0,0, 0,0,1,1,0,1,6));
        tbl.push_back(mk(0,1,1,9, 0,0,1,0,0,2,6));
        tbl.push_back(mk(0,1,0,0, 0,0,1,0,0,3,6));
        tbl.push_back(mk(1,1,0,0, 0,0,0,1,0,0,3));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,3));
        tbl.push_back(mk(0,1,0,0, 0,0,1,1,0,1,3));
        tbl.push_back(mk(0,1,0,0, 0,1,1,1,0,2,3));
        tbl.push_back(mk(0,1,0,0, 1,0,1,1,0,0,3));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].en, tbl[i].vld, int'(tbl[i].d),
                tbl[i].exp.tick, tbl[i].exp.last, tbl[i].exp.busy, tbl[i].exp.rdy,
                tbl[i].exp.err, int'(tbl[i].exp.phase), int'(tbl[i].exp.div));
        end

        // Divisor 2 accepted on a last cycle waits one more full period before taking effect.
        cyc("lastacc_p1",  0,1,0,0, 0,0,1,1,0,1,3);
        cyc("lastacc_p2",  0,1,0,0, 0,1,1,1,0,2,3);
        cyc("lastacc_acc", 0,1,1,2, 1,0,1,0,0,0,3);
        cyc("lastacc_w1",  0,1,0,0, 0,0,1,0,0,1,3);
        cyc("lastacc_w2",  0,1,0,0, 0,1,1,0,0,2,3);
        cyc("lastacc_app", 0,1,0,0, 1,0,1,1,0,0,2);
        // Divisor 2: tick and last alternate every cycle.
        for (int k = 0; k < 3; k++) begin
            cyc("div2_last", 0,1,0,0, 0,1,1,1,0,1,2);
            cyc("div2_tick", 0,1,0,0, 1,0,1,1,0,0,2);
        end
        cyc("div2_last", 0,1,0,0, 0,1,1,1,0,1,2);
        // en falls together with an accepted divisor: stop and apply at the IDLE boundary.
        cyc("simul_acc",  0,0,1,4, 1,0,1,0,0,0,2);
        cyc("simul_last", 0,0,0,0, 0,1,1,0,0,1,2);
        cyc("simul_idle", 0,0,0,0, 0,0,0,1,0,0,4);
        cyc("simul_hold", 0,0,0,0, 0,0,0,1,0,0,4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
